imem_loader: RTL and testbench

- Writer side of the instruction memory: loads a program image from a byte stream into the instruction RAM, which the processor core then only reads.
- Sits between a byte source (UART receiver or switch/strobe front end) and the instruction RAM write port (data/wren/address).
- Holds the core in reset while loading.
- Reports done/error status for the seven-segment and LED outputs.

---
 rtl/imem_loader_pkg.sv | 28 ++
 rtl/imem_loader_timer.sv | 32 +++
 rtl/imem_loader.sv | 180 ++++++++++++++++++
 tb/tb_imem_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DAT_HI = 3'd3,
        DAT_LO = 3'd4,
        WRITE  = 3'd5,
        DONE   = 3'd6,
        ERROR  = 3'd7
    } state_e;

    // States in which a byte may be taken from the source.
    function automatic logic is_rx_state(input state_e s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DAT_HI) || (s == DAT_LO);
    endfunction

    // States that make up an active load (header through last write).
    function automatic logic is_load_state(input state_e s);
        return is_rx_state(s) || (s == WRITE);
    endfunction

endpackage

// File: rtl/imem_loader_timer.sv
// Inter-byte watchdog: down-counter reloaded on clear, decremented while
// enabled, and flagging expiry once it has counted CYCLES-1 steps.
module imem_loader_timer #(
    parameter int CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q;

    // Reload on clear, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= LOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Zero means CYCLES-1 idle cycles have already elapsed since the clear.
    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, big-endian 16-bit program image from a byte
// stream into the instruction RAM write port, holding the core in reset
// while the load is in progress.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                byte_valid,
    input  logic [BYTE_W-1:0]   byte_data,
    output logic                byte_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_data,
    output logic                mem_wren,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done,
    output logic                err_len,
    output logic                err_timeout,
    output logic [ADDR_W:0]     words_loaded
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e              state_q, state_d;
    logic [15:0]         len_q;
    logic [BYTE_W-1:0]   hi_q;
    logic [ADDR_W:0]     idx_q;
    logic [ADDR_W:0]     words_q;
    logic                byte_ready_q;
    logic                mem_wren_q;
    logic                cpu_hold_q;
    logic                busy_q;
    logic                done_q;
    logic                err_len_q;
    logic                err_to_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [WORD_W-1:0]   mem_data_q;

    logic                xfer;
    logic                start_load;
    logic                timed;
    logic                tmr_clr;
    logic                tmr_expire;
    logic                timeout_hit;
    logic [15:0]         len_full;
    logic                len_zero;
    logic                len_bad;
    logic [ADDR_W:0]     idx_inc;
    logic                last_word;

    // A byte moves only when the registered ready meets a valid source.
    assign xfer        = byte_valid && byte_ready_q;
    // start is honoured only while no load is running.
    assign start_load  = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
    assign timed       = (state_q == LEN_LO) || (state_q == DAT_HI) || (state_q == DAT_LO);
    // A transfer in the expiry cycle wins over the timeout.
    assign timeout_hit = timed && !xfer && tmr_expire;
    assign tmr_clr     = xfer || start_load;

    // Full header length as it will be once the low byte is latched.
    assign len_full  = {len_q[15:8], byte_data};
    assign len_zero  = (len_full == 16'd0);
    assign len_bad   = ({16'd0, len_full} > 32'(DEPTH));
    assign idx_inc   = idx_q + 1'b1;
    assign last_word = (32'(idx_inc) == {16'd0, len_q});

    imem_loader_timer #(
        .CYCLES (TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmr_clr),
        .en_i     (timed),
        .expire_o (tmr_expire)
    );

    // Next-state selection for the frame parser.
    always_comb begin
        state_d = state_q;
        if (timeout_hit) begin
            state_d = ERROR;
        end else begin
            case (state_q)
                IDLE:   if (start_load) state_d = LEN_HI;
                LEN_HI: if (xfer) state_d = LEN_LO;
                LEN_LO: begin
                    if (xfer) begin
                        if (len_zero)     state_d = DONE;
                        else if (len_bad) state_d = ERROR;
                        else              state_d = DAT_HI;
                    end
                end
                DAT_HI: if (xfer) state_d = DAT_LO;
                DAT_LO: if (xfer) state_d = WRITE;
                WRITE:  state_d = last_word ? DONE : DAT_HI;
                DONE:   if (start_load) state_d = LEN_HI;
                ERROR:  if (start_load) state_d = LEN_HI;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, registered output decode, and datapath latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            hi_q         <= '0;
            idx_q        <= '0;
            words_q      <= '0;
            byte_ready_q <= 1'b0;
            mem_wren_q   <= 1'b0;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_len_q    <= 1'b0;
            err_to_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            byte_ready_q <= is_rx_state(state_d);
            busy_q       <= is_load_state(state_d);
            cpu_hold_q   <= is_load_state(state_d) || (state_d == ERROR);
            done_q       <= (state_d == DONE);
            mem_wren_q   <= (state_d == WRITE);

            if (start_load) begin
                err_len_q <= 1'b0;
                err_to_q  <= 1'b0;
                words_q   <= '0;
                idx_q     <= '0;
            end

            if (timeout_hit) begin
                err_to_q <= 1'b1;
            end

            if (xfer) begin
                case (state_q)
                    LEN_HI: len_q[15:8] <= byte_data;
                    LEN_LO: begin
                        len_q[7:0] <= byte_data;
                        idx_q      <= '0;
                        if (!len_zero && len_bad) err_len_q <= 1'b1;
                    end
                    DAT_HI: hi_q <= byte_data;
                    DAT_LO: begin
                        // Address and data stay put after the write cycle.
                        mem_addr_q <= idx_q[ADDR_W-1:0];
                        mem_data_q <= {hi_q, byte_data};
                    end
                    default: ;
                endcase
            end

            if (state_q == WRITE) begin
                words_q <= idx_inc;
                idx_q   <= idx_inc;
            end
        end
    end

    assign byte_ready   = byte_ready_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data     = mem_data_q;
    assign mem_wren     = mem_wren_q;
    assign cpu_hold     = cpu_hold_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_len      = err_len_q;
    assign err_timeout  = err_to_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed/randomized bench for imem_loader with a frame-level reference
// model: expected writes are derived from the header and payload words.
module tb_imem_loader;

    localparam int AW    = 4;
    localparam int TO    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic          mem_wren;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err_len;
    logic          err_timeout;
    logic [AW:0]   words_loaded;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0]   ram [DEPTH];
    logic [AW-1:0] wa_q [$];
    logic [15:0]   wd_q [$];
    logic [15:0]   words [$];

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_W      (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_wren     (mem_wren),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .err_len      (err_len),
        .err_timeout  (err_timeout),
        .words_loaded (words_loaded)
    );

    // Behaves as the instruction RAM and logs every write in order.
    always @(posedge clk) begin
        if (mem_wren === 1'b1) begin
            ram[mem_addr] <= mem_data;
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles and hold it until taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) check("ready_wait", 32'(waited), 32'd0);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic fill_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(16'($urandom()));
    endtask

    task automatic send_header(input int n, input int gmax);
        logic [15:0] nn;
        nn = 16'(n);
        send_byte(nn[15:8], $urandom_range(gmax, 0));
        send_byte(nn[7:0],  $urandom_range(gmax, 0));
    endtask

    task automatic send_word(input int i, input int gmax);
        logic [15:0] w;
        w = words[i];
        send_byte(w[15:8], $urandom_range(gmax, 0));
        send_byte(w[7:0],  $urandom_range(gmax, 0));
    endtask

    // Reference outcome of a complete frame of n words.
    task automatic check_load(input string tag, input int n);
        int exp_cnt;
        exp_cnt = (n > DEPTH) ? 0 : n;
        check({tag, "_nwr"}, 32'(wa_q.size()), 32'(exp_cnt));
        for (int i = 0; i < exp_cnt && i < wa_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wa_q[i]), 32'(i));
            check($sformatf("%s_data%0d", tag, i), 32'(wd_q[i]), 32'(words[i]));
        end
        check({tag, "_done"},  32'(done),         32'(n <= DEPTH));
        check({tag, "_elen"},  32'(err_len),      32'(n > DEPTH));
        check({tag, "_hold"},  32'(cpu_hold),     32'(n > DEPTH));
        check({tag, "_busy"},  32'(busy),         32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'(exp_cnt));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(byte_ready),   32'd0);
        check({tag, "_wren"},  32'(mem_wren),     32'd0);
        check({tag, "_hold"},  32'(cpu_hold),     32'd0);
        check({tag, "_busy"},  32'(busy),         32'd0);
        check({tag, "_done"},  32'(done),         32'd0);
        check({tag, "_elen"},  32'(err_len),      32'd0);
        check({tag, "_eto"},   32'(err_timeout),  32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd0);
        check({tag, "_addr"},  32'(mem_addr),     32'd0);
        check({tag, "_data"},  32'(mem_data),     32'd0);
    endtask

    initial begin
        logic [7:0] lo;
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // Two-word image with byte_valid held high throughout.
        wa_q.delete(); wd_q.delete();
        words.delete(); words.push_back(16'h1234); words.push_back(16'hABCD);
        pulse_start();
        check("s1_ready_after_start", 32'(byte_ready), 32'd1);
        check("s1_hold_after_start",  32'(cpu_hold),   32'd1);
        send_header(2, 0);
        send_word(0, 0);
        send_word(1, 0);
        check("s1_wren_next_cycle", 32'(mem_wren), 32'd1);
        check("s1_wr_addr",         32'(mem_addr), 32'd1);
        check("s1_wr_data",         32'(mem_data), 32'hABCD);
        check("s1_hold_in_write",   32'(cpu_hold), 32'd1);
        @(negedge clk);
        check("s1_hold_drop", 32'(cpu_hold), 32'd0);
        check("s1_wren_drop", 32'(mem_wren), 32'd0);
        check("s1_data_hold", 32'(mem_data), 32'hABCD);
        check_load("s1", 2);

        // Empty image goes straight to DONE.
        wa_q.delete(); wd_q.delete(); words.delete();
        pulse_start();
        check("s2_done_cleared", 32'(done),         32'd0);
        check("s2_words_clear",  32'(words_loaded), 32'd0);
        send_header(0, 2);
        check_load("s2", 0);

        // Header longer than DEPTH is rejected without writes.
        wa_q.delete(); wd_q.delete(); fill_words(17);
        pulse_start();
        send_header(17, 1);
        @(negedge clk);
        check_load("s3", 17);
        check("s3_ready", 32'(byte_ready), 32'd0);

        // Full-depth image with random byte gaps; restart clears err_len.
        wa_q.delete(); wd_q.delete(); fill_words(16);
        pulse_start();
        check("s4_elen_cleared", 32'(err_len), 32'd0);
        check("s4_busy",         32'(busy),    32'd1);
        send_header(16, 3);
        for (int i = 0; i < 16; i++) send_word(i, 3);
        @(negedge clk);
        check_load("s4", 16);

        // One high byte then silence: timeout after 8 idle cycles.
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_header(1, 0);
        send_byte(8'h55, 0);
        repeat (7) @(negedge clk);
        check("s5_no_err_yet", 32'(err_timeout), 32'd0);
        check("s5_busy_yet",   32'(busy),        32'd1);
        @(negedge clk);
        check("s5_eto",   32'(err_timeout), 32'd1);
        check("s5_hold",  32'(cpu_hold),    32'd1);
        check("s5_busy",  32'(busy),        32'd0);
        check("s5_done",  32'(done),        32'd0);
        check("s5_nwr",   32'(wa_q.size()), 32'd0);

        // Same, but the low byte arrives in the expiry cycle.
        wa_q.delete(); wd_q.delete();
        lo = 8'($urandom());
        words.delete(); words.push_back({8'h55, lo});
        pulse_start();
        check("s6_eto_cleared", 32'(err_timeout), 32'd0);
        send_header(1, 0);
        send_byte(8'h55, 0);
        send_byte(lo, 7);
        check("s6_eto",  32'(err_timeout), 32'd0);
        check("s6_wren", 32'(mem_wren),    32'd1);
        @(negedge clk);
        check_load("s6", 1);
        check("s6_eto_final", 32'(err_timeout), 32'd0);

        // Reset during the low byte of word 3 of a 5-word load.
        wa_q.delete(); wd_q.delete(); fill_words(5);
        pulse_start();
        send_header(5, 1);
        for (int i = 0; i < 3; i++) send_word(i, 1);
        lo = words[3][15:8];
        send_byte(lo, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("s7_rst");
        check("s7_nwr", 32'(wa_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) check($sformatf("s7_ram%0d", i), 32'(ram[i]), 32'(words[i]));
        wa_q.delete(); wd_q.delete(); fill_words(5);
        pulse_start();
        send_header(5, 2);
        for (int i = 0; i < 5; i++) send_word(i, 2);
        @(negedge clk);
        check_load("s7_reload", 5);

        // Random gaps plus an ignored start pulse in the middle.
        wa_q.delete(); wd_q.delete(); fill_words(4);
        pulse_start();
        send_header(4, 3);
        send_word(0, 3);
        send_word(1, 3);
        pulse_start();
        check("s8_busy_after_start", 32'(busy), 32'd1);
        send_word(2, 3);
        send_word(3, 3);
        @(negedge clk);
        check_load("s8", 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
